// File: rtl/mux_scan_n.sv
`default_nettype none
// ============================================================================
// Module   : mux_scan_n
// Brief    : N-channel, W-bit registered mux with manual select and an
//            automatic channel scanner driven by a DIV-cycle dwell prescaler.
//            Optional macro MUX_SCAN_BLANK_EN blanks dout on scan advances.
// Revision : 1.0 - initial release
// ============================================================================
module mux_scan_n #(
   parameter int N     = 4,
   parameter int W     = 1,
   parameter int SEL_W = (N > 1) ? $clog2(N) : 1,
   parameter int DIV   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N*W-1:0]   din,
   input  logic [SEL_W-1:0] sel,
   input  logic             mode,
   input  logic             en,
   output logic [W-1:0]     dout,
   output logic [SEL_W-1:0] ch,
   output logic             tick
);

   localparam int               C_PC_W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [C_PC_W-1:0] C_PC_LAST = C_PC_W'(DIV - 1);
   localparam logic [SEL_W-1:0]  C_CH_LAST = SEL_W'(N - 1);

   generate
      if (N < 2 || N > 256 || W < 1 || DIV < 1) begin : g_param_check
         $error("mux_scan_n: parameter out of range");
      end
   endgenerate

   logic [C_PC_W-1:0] r_pc;
   logic              r_mode_q;
   logic [W-1:0]      r_dout;
   logic [SEL_W-1:0]  r_ch;
   logic              r_tick;

   logic [C_PC_W-1:0] w_pc_next;
   logic [SEL_W-1:0]  w_ch_next;
   logic              w_adv;
   logic [W-1:0]      w_sel_data;
   logic [W-1:0]      w_dout_next;

   // Scanner: entry into scan mode restarts at channel 0 with a fresh dwell.
   always_comb begin
      w_ch_next = r_ch;
      w_pc_next = r_pc;
      w_adv     = 1'b0;
      if (!mode) begin
         w_ch_next = sel;
         w_pc_next = '0;
      end else if (!r_mode_q) begin
         w_ch_next = '0;
         w_pc_next = '0;
      end else if (en) begin
         if (r_pc == C_PC_LAST) begin
            w_adv     = 1'b1;
            w_pc_next = '0;
            w_ch_next = (r_ch == C_CH_LAST) ? '0 : r_ch + SEL_W'(1);
         end else begin
            w_pc_next = r_pc + C_PC_W'(1);
         end
      end
   end

   // Indices beyond N-1 (non-power-of-2 N) select zero.
   always_comb begin
      w_sel_data = '0;
      for (int k = 0; k < N; k++) begin
         if (w_ch_next == SEL_W'(k)) begin
            w_sel_data = din[k*W +: W];
         end
      end
   end

`ifdef MUX_SCAN_BLANK_EN
   generate
      if (DIV < 2) begin : g_blank_div_check
         $error("mux_scan_n: MUX_SCAN_BLANK_EN requires DIV >= 2");
      end
   endgenerate

   // Blank one cycle on every advance to avoid ghosting on shared segments.
   assign w_dout_next = w_adv ? '0 : w_sel_data;
`else
   assign w_dout_next = w_sel_data;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc     <= '0;
         r_mode_q <= 1'b0;
         r_dout   <= '0;
         r_ch     <= '0;
         r_tick   <= 1'b0;
      end else begin
         r_pc     <= w_pc_next;
         r_mode_q <= mode;
         r_dout   <= w_dout_next;
         r_ch     <= w_ch_next;
         r_tick   <= w_adv;
      end
   end

   assign dout = r_dout;
   assign ch   = r_ch;
   assign tick = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_n.sv
`default_nettype none
// Testbench for mux_scan_n: directed vectors with literal expectations plus a
// per-cycle comparison against a step-count based behavioural model.
module tb_mux_scan_n;

   localparam int W   = 4;
   localparam int DIV = 3;
`ifdef MUX_SCAN_BLANK_EN
   localparam bit BLANK = 1'b1;
`else
   localparam bit BLANK = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic [15:0] din;
   logic [11:0] din3;
   logic [1:0]  sel;
   logic        mode;
   logic        en;
   logic [3:0]  dout4, dout3;
   logic [1:0]  ch4, ch3;
   logic        tick4, tick3;

   int checks   = 0;
   int failures = 0;

   assign din3 = din[11:0];

   mux_scan_n #(.N(4), .W(W), .DIV(DIV)) u_dut4 (
      .clk(clk), .rst(rst), .din(din), .sel(sel), .mode(mode), .en(en),
      .dout(dout4), .ch(ch4), .tick(tick4)
   );

   mux_scan_n #(.N(3), .W(W), .DIV(DIV)) u_dut3 (
      .clk(clk), .rst(rst), .din(din3), .sel(sel), .mode(mode), .en(en),
      .dout(dout3), .ch(ch3), .tick(tick3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Scan position is the number of enabled cycles since scan start;
   // channel = (steps / DIV) mod N, advance whenever steps hits a multiple of DIV.
   int         m_steps [2];
   bit         m_prev  [2];
   logic [1:0] e_ch    [2];
   logic [3:0] e_dout  [2];
   logic       e_tick  [2];
   bit         m_live = 1'b0;

   function automatic logic [3:0] chan(input logic [15:0] d, input int c, input int n);
      if (c >= n) return 4'h0;
      return d[c*4 +: 4];
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         int n;
         bit adv;
         n   = (i == 0) ? 4 : 3;
         adv = 1'b0;
         if (rst) begin
            m_steps[i] = 0;
            m_prev[i]  = 1'b0;
            e_ch[i]    = 2'd0;
            e_dout[i]  = 4'h0;
            e_tick[i]  = 1'b0;
         end else begin
            if (!mode) begin
               m_steps[i] = 0;
               e_ch[i]    = sel;
            end else if (!m_prev[i]) begin
               m_steps[i] = 0;
               e_ch[i]    = 2'd0;
            end else if (en) begin
               m_steps[i] = m_steps[i] + 1;
               adv        = (m_steps[i] % DIV) == 0;
               e_ch[i]    = 2'((m_steps[i] / DIV) % n);
            end
            e_tick[i] = adv;
            e_dout[i] = (BLANK && adv) ? 4'h0 : chan(din, int'(e_ch[i]), n);
            m_prev[i] = mode;
         end
      end
      m_live = 1'b1;
   end

   always @(negedge clk) begin
      if (m_live) begin
         check("model_ch_n4",   32'(ch4),   32'(e_ch[0]));
         check("model_dout_n4", 32'(dout4), 32'(e_dout[0]));
         check("model_tick_n4", 32'(tick4), 32'(e_tick[0]));
         check("model_ch_n3",   32'(ch3),   32'(e_ch[1]));
         check("model_dout_n3", 32'(dout3), 32'(e_dout[1]));
         check("model_tick_n3", 32'(tick3), 32'(e_tick[1]));
      end
   end

   // ---------------- directed stimulus ----------------
   int seq_ch   [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
   int seq_tick [13] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1};
   int nib      [4]  = '{10, 11, 12, 13};
   int seq3_ch  [10] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 0};
   int seq3_tk  [10] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1};

   function automatic logic [31:0] blanked(input int tk, input int v);
      return (BLANK && tk != 0) ? 32'd0 : 32'(v);
   endfunction

   initial begin
      rst  = 1'b1;
      mode = 1'b1;
      en   = 1'b1;
      sel  = 2'd0;
      din  = 16'hDCBA;

      repeat (2) @(negedge clk);
      check("reset_dout", 32'(dout4), 32'h0);
      check("reset_ch",   32'(ch4),   32'h0);
      check("reset_tick", 32'(tick4), 32'h0);
      rst = 1'b0;

      // Sweep: entry cycle first, then DIV cycles per channel and a wrap.
      for (int k = 0; k < 13; k++) begin
         @(negedge clk);
         check("sweep_ch",   32'(ch4),   32'(seq_ch[k]));
         check("sweep_tick", 32'(tick4), 32'(seq_tick[k]));
         check("sweep_dout", 32'(dout4), blanked(seq_tick[k], nib[seq_ch[k]]));
      end

      // Move to ch=2, pc=1 and freeze.
      repeat (7) @(negedge clk);
      check("pre_freeze_ch", 32'(ch4), 32'd2);
      en = 1'b0;
      @(negedge clk);
      check("freeze_ch",   32'(ch4),   32'd2);
      check("freeze_dout", 32'(dout4), 32'hC);
      @(negedge clk);
      check("freeze_ch",   32'(ch4),   32'd2);
      din = 16'hD5BA;
      @(negedge clk);
      check("freeze_live_dout", 32'(dout4), 32'h5);
      check("freeze_tick",      32'(tick4), 32'd0);
      repeat (2) @(negedge clk);
      check("freeze_ch_end", 32'(ch4), 32'd2);
      en = 1'b1;
      @(negedge clk);
      check("resume_ch1",   32'(ch4),   32'd2);
      check("resume_tick1", 32'(tick4), 32'd0);
      @(negedge clk);
      check("resume_ch2",   32'(ch4),   32'd3);
      check("resume_tick2", 32'(tick4), 32'd1);
      check("resume_dout2", 32'(dout4), blanked(1, 13));

      // Mode exit then re-entry.
      mode = 1'b0;
      sel  = 2'd1;
      @(negedge clk);
      check("exit_ch",   32'(ch4),   32'd1);
      check("exit_dout", 32'(dout4), 32'hB);
      mode = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("entry_ch",   32'(ch4),   32'(seq_ch[k]));
         check("entry_tick", 32'(tick4), 32'(seq_tick[k]));
      end

      // Reset mid-dwell.
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_ch",   32'(ch4),   32'd0);
      check("midrst_dout", 32'(dout4), 32'h0);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("restart_ch",   32'(ch4),   32'(seq_ch[k]));
         check("restart_tick", 32'(tick4), 32'(seq_tick[k]));
      end

      // Out-of-range select on the N=3 instance.
      mode = 1'b0;
      sel  = 2'd3;
      @(negedge clk);
      check("n3_sel3_ch",   32'(ch3),   32'd3);
      check("n3_sel3_dout", 32'(dout3), 32'h0);
      check("n4_sel3_dout", 32'(dout4), 32'hD);
      check("man_tick",     32'(tick4), 32'd0);
      sel = 2'd2;
      @(negedge clk);
      check("n3_sel2_dout", 32'(dout3), 32'h5);

      // N=3 scan wraps after channel 2.
      mode = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("n3_scan_ch",   32'(ch3),   32'(seq3_ch[k]));
         check("n3_scan_tick", 32'(tick3), 32'(seq3_tk[k]));
      end

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mux_scan_n.md
# mux_scan_n

Parametrised N-channel, W-bit registered multiplexer: the next generation of the team's 4:1 single-bit mux. It has two modes: manual select, and an automatic channel scanner with a programmable dwell prescaler. It sits in front of time-multiplexed outputs (7-segment digit drivers, LED banks, serial probes). It replaces hand-built trees of 2:1 muxes with one registered, glitch-free block.

## Interface
- N, 4: number of channels, 2..256
- W, 1: bits per channel, ≥1
- SEL_W, clog2(N) (min 1): select/channel index width
- DIV, 1: scan dwell in clock cycles per channel, ≥1
- clk  in  1  rising-edge clock, the only clock
- rst  in  1  synchronous, active-high reset
- din  in  N*W  packed channels; channel k at din[k*W +: W]
- sel  in  SEL_W  channel select, used in manual mode
- mode  in  1  0 = manual, 1 = scan
- en  in  1  scan enable; freezes the scanner when low
- dout  out  W  registered selected data
- ch  out  SEL_W  channel index currently driving dout
- tick  out  1  one-cycle pulse on each scan channel advance

## Operation
- Every edge: ch <= ch_next; dout <= din[ch_next] (0 if ch_next ≥ N); tick <= adv.
- dout and ch are always aligned. ch names the source of the dout value presented in the same cycle.
- Manual mode (mode=0):
  - ch_next = sel.
  - Prescaler held at 0; tick = 0.
  - sel ≥ N (non-power-of-2 N): ch = sel, dout = 0.
- Scan mode (mode=1):
  - Prescaler pc counts 0..DIV-1 while en=1.
  - adv = en & (pc == DIV-1); pc then wraps to 0.
  - On adv: ch_next = (ch == N-1) ? 0 : ch+1. Otherwise ch_next = ch.
  - DIV=1: ch advances every enabled cycle.
- en=0 in scan mode: pc and ch freeze; tick = 0; dout keeps tracking live din[ch].
- Mode entry 0→1 (detected on a registered copy of mode): ch_next = 0 and pc cleared. Scanning always starts at channel 0 with a full DIV dwell.
- Mode exit 1→0: ch_next = sel immediately; pc cleared.
- sel is ignored in scan mode.
- No state besides pc, ch, dout, tick and the mode history bit.

## Timing
- Reset values (rst=1 at an edge): dout = 0, ch = 0, tick = 0, pc = 0, mode history = 0.
- rst has priority over every other input.
- Reset mid-scan restarts at channel 0 after release.
- Data latency is 1 cycle: a din or sel change is visible on dout after the next edge.
- Scan dwell is exactly DIV cycles per channel with en held high. The full sweep period is N*DIV cycles.
- tick is high in the first cycle of each new channel, coincident with the new ch/dout.
- The channel wrap N-1→0 behaves like any other advance and pulses tick.
- Mode entry and en toggling never pulse tick.

## Configuration
- Macro: MUX_SCAN_BLANK_EN.
- Defined:
  - In scan mode, on every advance cycle (tick=1), dout = 0 for that single cycle.
  - din[ch] appears from the following cycle. This suppresses ghosting on shared display segments.
  - Effective visible dwell is DIV-1 cycles. DIV must be ≥2; DIV=1 is a compile-time error.
  - Manual mode is unaffected.
- Undefined: no blanking; dout = din[ch] on the tick cycle.

## Test plan
- Reset: with N=4, W=4, DIV=3, hold rst=1 for 2 cycles while din=16'hDCBA, mode=1. Required: dout=0, ch=0, tick=0. After release: dout=4'hA, ch=0.
- Manual select: mode=0, din=16'hDCBA, sel stepped 0,1,2,3. Required: dout = A,B,C,D, each one cycle after the sel change; tick stays 0.
- Scan sweep: mode=1, en=1, DIV=3. Required:
  - ch sequence 0,0,0,1,1,1,2,2,2,3,3,3,0.
  - tick high on the first cycle of ch=1, 2, 3 and 0 (the wrap).
  - dout matches din[ch] on every cycle.
- Freeze: en=0 for 5 cycles mid-dwell at ch=2, pc=1, while din channel 2 changes to 4'h5. Required: ch stays 2 and no tick. dout shows 5 one cycle after the din change. After en returns to 1, the advance occurs 2 enabled cycles later.
- Mode/reset boundaries:
  - Switch 1→0 at ch=3 with sel=1: ch=1 on the next cycle.
  - Switch 0→1: scan restarts at ch=0 with a full 3-cycle dwell.
  - Assert rst mid-dwell: ch=0, pc=0.
- Non-power-of-2 and blanking: with N=3, manual sel=3 gives dout=0, ch=3. With MUX_SCAN_BLANK_EN and DIV=3, dout=0 on each tick cycle, then din[ch] for the next 2 cycles.
